// File: rtl/vram_fill_ctrl.sv
// vram_fill_ctrl: write-port sequencer/arbiter for the double-buffered VRAM.
// Shares one write port between CPU stores, a full-screen clear engine and a
// rectangle-fill engine, and performs vsync-aligned front-buffer swaps.
// Optional macro FILL_ABORT_EN adds an abort input that cancels CLS/FILL.
module vram_fill_ctrl #(
   parameter int FB_W = 320,
   parameter int FB_H = 480,
   parameter int AW   = 20
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] cpu_addr,
   input  logic [7:0]    cpu_data,
   input  logic          cpu_we,
   input  logic          cpu_re,
   input  logic          cls_rq,
   output logic          cls_ack,
   input  logic [8:0]    fill_x0,
   input  logic [8:0]    fill_y0,
   input  logic [8:0]    fill_w,
   input  logic [8:0]    fill_h,
   input  logic [7:0]    fill_val,
   input  logic          fill_rq,
   output logic          fill_ack,
   output logic          busy,
   input  logic          swap_rq,
   input  logic          vsync,
   output logic          bufswap,
   output logic          swap_ack,
`ifdef FILL_ABORT_EN
   input  logic          abort,
`endif
   output logic [AW-1:0] vmem_addr,
   output logic [7:0]    vmem_data,
   output logic          vmem_we,
   output logic          vmem_re
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(FB_W * FB_H - 1);
   localparam logic [10:0]   W11       = 11'(FB_W);
   localparam logic [10:0]   H11       = 11'(FB_H);

   typedef enum logic [1:0] {IDLE, SETUP, CLS, FILL} state_t;
   state_t state, state_n;

   // cnt is the clear address in CLS and the current row base in FILL
   logic [AW-1:0] cnt, cnt_n;
   logic [8:0]    col, col_n, row, row_n, wc, wc_n, hc, hc_n;
   logic [8:0]    x0_q, y0_q, w_q, h_q;
   logic [7:0]    val_q;
   logic          cls_ack_n, fill_ack_n;
   logic          eng_we;
   logic [AW-1:0] eng_addr;
   logic [7:0]    eng_data;
   logic          abort_i;
   logic [10:0]   xr, yr;
   logic [8:0]    wc_c, hc_c;
   logic [AW-1:0] base_c;
   logic [2:0]    vs_sync;
   logic          vs_fall, swap_pending;

`ifdef FILL_ABORT_EN
   assign abort_i = abort;
`else
   assign abort_i = 1'b0;
`endif

   // Clipping: room left to the right/bottom edge, zero when origin is off-screen
   assign xr     = ({2'b0, x0_q} >= W11) ? 11'd0 : W11 - {2'b0, x0_q};
   assign yr     = ({2'b0, y0_q} >= H11) ? 11'd0 : H11 - {2'b0, y0_q};
   assign wc_c   = 9'(({2'b0, w_q} < xr) ? {2'b0, w_q} : xr);
   assign hc_c   = 9'(({2'b0, h_q} < yr) ? {2'b0, h_q} : yr);
   assign base_c = AW'(y0_q) * AW'(FB_W) + AW'(x0_q);

   // Engine state register plus captured rectangle parameters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         col   <= '0;
         row   <= '0;
         wc    <= '0;
         hc    <= '0;
         x0_q  <= '0;
         y0_q  <= '0;
         w_q   <= '0;
         h_q   <= '0;
         val_q <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         col   <= col_n;
         row   <= row_n;
         wc    <= wc_n;
         hc    <= hc_n;
         if (state == IDLE) begin
            x0_q  <= fill_x0;
            y0_q  <= fill_y0;
            w_q   <= fill_w;
            h_q   <= fill_h;
            val_q <= fill_val;
         end
      end
   end

   // Next-state, engine write request and ack generation; CPU store stalls engine
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      col_n      = col;
      row_n      = row;
      wc_n       = wc;
      hc_n       = hc;
      cls_ack_n  = 1'b0;
      fill_ack_n = 1'b0;
      eng_we     = 1'b0;
      eng_addr   = cnt;
      eng_data   = 8'h00;
      case (state)
         IDLE: begin
            if (cls_rq) begin
               state_n = CLS;
               cnt_n   = '0;
            end else if (fill_rq) begin
               state_n = SETUP;
            end
         end
         SETUP: begin
            if (wc_c == 9'd0 || hc_c == 9'd0) begin
               state_n    = IDLE;
               fill_ack_n = 1'b1;
            end else begin
               state_n = FILL;
               wc_n    = wc_c;
               hc_n    = hc_c;
               cnt_n   = base_c;
               col_n   = '0;
               row_n   = '0;
            end
         end
         CLS: begin
            if (abort_i) begin
               state_n   = IDLE;
               cls_ack_n = 1'b1;
            end else if (!cpu_we) begin
               eng_we   = 1'b1;
               eng_addr = cnt;
               cnt_n    = cnt + AW'(1);
               if (cnt == LAST_ADDR) begin
                  state_n   = IDLE;
                  cls_ack_n = 1'b1;
               end
            end
         end
         FILL: begin
            if (abort_i) begin
               state_n    = IDLE;
               fill_ack_n = 1'b1;
            end else if (!cpu_we) begin
               eng_we   = 1'b1;
               eng_addr = cnt + AW'(col);
               eng_data = val_q;
               if (col == wc - 9'd1) begin
                  col_n = '0;
                  cnt_n = cnt + AW'(FB_W);
                  row_n = row + 9'd1;
                  if (row == hc - 9'd1) begin
                     state_n    = IDLE;
                     fill_ack_n = 1'b1;
                  end
               end else begin
                  col_n = col + 9'd1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Registered write port, acks and busy (all aligned one cycle after grant)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vmem_addr <= '0;
         vmem_data <= '0;
         vmem_we   <= 1'b0;
         vmem_re   <= 1'b0;
         cls_ack   <= 1'b0;
         fill_ack  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         cls_ack  <= cls_ack_n;
         fill_ack <= fill_ack_n;
         busy     <= (state != IDLE);
         vmem_we  <= cpu_we | eng_we;
         vmem_re  <= cpu_re & ~cpu_we & ~eng_we;
         if (cpu_we) begin
            vmem_addr <= cpu_addr;
            vmem_data <= cpu_data;
         end else if (eng_we) begin
            vmem_addr <= eng_addr;
            vmem_data <= eng_data;
         end else if (cpu_re) begin
            vmem_addr <= cpu_addr;
            vmem_data <= '0;
         end else begin
            vmem_addr <= '0;
            vmem_data <= '0;
         end
      end
   end

   // vsync synchroniser; falling edge taken on the synchronised value
   assign vs_fall = vs_sync[2] & ~vs_sync[1];

   // Swap scheduling: pending flag merged, executed on vsync fall while idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vs_sync      <= 3'b111;
         swap_pending <= 1'b0;
         bufswap      <= 1'b0;
         swap_ack     <= 1'b0;
      end else begin
         vs_sync  <= {vs_sync[1:0], vsync};
         swap_ack <= 1'b0;
         if (vs_fall && swap_pending && state == IDLE) begin
            bufswap      <= ~bufswap;
            swap_ack     <= 1'b1;
            swap_pending <= swap_rq;
         end else if (swap_rq) begin
            swap_pending <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vram_fill_ctrl.sv
// Bench for vram_fill_ctrl: directed and random fills against a rectangle
// model, a scaled-down full clear, CPU stalls, swap scheduling and async reset.
module tb_vram_fill_ctrl;

   localparam int FB_W = 320;
   localparam int FB_H = 60;
   localparam int AW   = 20;

   logic          clk = 0, rst = 1;
   logic [AW-1:0] cpu_addr = '0;
   logic [7:0]    cpu_data = '0;
   logic          cpu_we = 0, cpu_re = 0, cls_rq = 0, fill_rq = 0;
   logic [8:0]    fill_x0 = '0, fill_y0 = '0, fill_w = '0, fill_h = '0;
   logic [7:0]    fill_val = '0;
   logic          swap_rq = 0, vsync = 1;
   logic          cls_ack, fill_ack, busy, bufswap, swap_ack;
   logic [AW-1:0] vmem_addr;
   logic [7:0]    vmem_data;
   logic          vmem_we, vmem_re;
`ifdef FILL_ABORT_EN
   logic          abort = 0;
`endif

   int checks = 0, errors = 0;
   int fill_ack_n = 0, swap_ack_n = 0, re_clash = 0;
   logic cpu_we_d = 0;
   logic [27:0] eng_q[$], cpu_q[$];

   vram_fill_ctrl #(.FB_W(FB_W), .FB_H(FB_H), .AW(AW)) dut (
      .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
      .cpu_we(cpu_we), .cpu_re(cpu_re), .cls_rq(cls_rq), .cls_ack(cls_ack),
      .fill_x0(fill_x0), .fill_y0(fill_y0), .fill_w(fill_w), .fill_h(fill_h),
      .fill_val(fill_val), .fill_rq(fill_rq), .fill_ack(fill_ack), .busy(busy),
      .swap_rq(swap_rq), .vsync(vsync), .bufswap(bufswap), .swap_ack(swap_ack),
`ifdef FILL_ABORT_EN
      .abort(abort),
`endif
      .vmem_addr(vmem_addr), .vmem_data(vmem_data), .vmem_we(vmem_we),
      .vmem_re(vmem_re));

   always #5 clk = ~clk;

   // grant-cycle copy of cpu_we, to tag port writes as CPU or engine
   always @(posedge clk) cpu_we_d <= cpu_we;

   // port monitor
   always @(negedge clk) begin
      if (vmem_we) begin
         if (cpu_we_d) cpu_q.push_back({vmem_addr, vmem_data});
         else          eng_q.push_back({vmem_addr, vmem_data});
         if (vmem_re) re_clash++;
      end
      if (fill_ack) fill_ack_n++;
      if (swap_ack) swap_ack_n++;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Fill a rectangle, optionally with a 4-cycle CPU store burst, and compare
   // the engine write stream against the clipped rectangle it should cover.
   task automatic run_fill(input int x0, input int y0, input int w, input int h,
                           input logic [7:0] v, input int burst_at);
      logic [27:0] exp_q[$];
      logic [27:0] cexp_q[$];
      int wc, hc, fa0, bad, cyc;
      bit seen;
      wc = (x0 >= FB_W) ? 0 : ((w < FB_W - x0) ? w : FB_W - x0);
      hc = (y0 >= FB_H) ? 0 : ((h < FB_H - y0) ? h : FB_H - y0);
      for (int r = 0; r < hc; r++)
         for (int c = 0; c < wc; c++)
            exp_q.push_back({AW'((y0 + r) * FB_W + x0 + c), v});
      eng_q.delete(); cpu_q.delete();
      fa0 = fill_ack_n;
      fill_x0 = 9'(x0); fill_y0 = 9'(y0); fill_w = 9'(w); fill_h = 9'(h);
      fill_val = v; fill_rq = 1;
      tick();
      fill_rq = 0;
      fill_x0 = 9'($urandom); fill_y0 = 9'($urandom);
      fill_w = 9'($urandom); fill_h = 9'($urandom); fill_val = 8'($urandom);
      seen = 0;
      for (cyc = 0; cyc < 3000 && !(seen && cyc >= burst_at + 5); cyc++) begin
         cpu_we   = (cyc >= burst_at && cyc < burst_at + 4);
         cpu_addr = AW'(32'hE0000 + cyc);
         cpu_data = 8'(cyc ^ 8'hA5);
         if (cpu_we) cexp_q.push_back({cpu_addr, cpu_data});
         @(negedge clk);
         if (fill_ack) seen = 1;
         tick();
      end
      cpu_we = 0;
      tick(); tick();
      @(negedge clk);
      chk("fill_ack_seen", int'(seen), 1);
      chk("fill_ack_pulses", fill_ack_n - fa0, 1);
      chk("fill_nwrites", eng_q.size(), exp_q.size());
      bad = 0;
      foreach (exp_q[i]) if (i >= eng_q.size() || eng_q[i] !== exp_q[i]) bad++;
      chk("fill_sequence", bad, 0);
      bad = (cpu_q.size() == cexp_q.size()) ? 0 : 1;
      foreach (cexp_q[i]) if (i >= cpu_q.size() || cpu_q[i] !== cexp_q[i]) bad++;
      chk("cpu_store_pass", bad, 0);
      tick();
   endtask

   initial begin
      int i, bad;
      bit got;

      // reset state
      tick(); tick();
      @(negedge clk);
      chk("rst_vmem_we", vmem_we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_bufswap", bufswap, 0);
      chk("rst_acks", {cls_ack, fill_ack, swap_ack}, 0);
      tick();
      rst = 0;
      tick(); tick();

      // idle CPU read
      cpu_re = 1; cpu_addr = 20'h1234A;
      tick();
      chk("idle_read_re", vmem_re, 1);
      chk("idle_read_we", vmem_we, 0);
      chk("idle_read_addr", int'(vmem_addr), 32'h1234A);
      cpu_re = 0;
      tick();

      // full clear
      eng_q.delete();
      cls_rq = 1;
      tick();
      cls_rq = 0;
      i = 0; got = 0;
      while (i < FB_W * FB_H + 100 && !got) begin
         cpu_re = (i == 2000); cpu_addr = 20'h00ABC;
         @(negedge clk);
         if (cls_ack) begin
            got = 1;
            chk("busy_at_cls_ack", busy, 1);
         end
         if (i == 1000) chk("busy_mid_clear", busy, 1);
         if (i == 2001) chk("re_masked_by_engine", vmem_re, 0);
         tick();
         i++;
      end
      cpu_re = 0;
      chk("cls_ack_seen", int'(got), 1);
      @(negedge clk);
      chk("busy_after_cls", busy, 0);
      chk("cls_ack_single", cls_ack, 0);
      chk("cls_nwrites", eng_q.size(), FB_W * FB_H);
      bad = 0;
      foreach (eng_q[k]) if (eng_q[k] !== {AW'(k), 8'h00}) bad++;
      chk("cls_sequence", bad, 0);
      tick();

      // directed fills
      run_fill(10, 2, 3, 2, 8'h5A, 100);
      run_fill(318, FB_H - 1, 5, 5, 8'h33, 100);
      run_fill(320, 4, 5, 5, 8'h77, 100);
      run_fill(5, 3, 10, 3, 8'hC3, 6);
      run_fill(0, 0, 0, 4, 8'h11, 100);

      // random fills with random CPU bursts
      for (int n = 0; n < 8; n++)
         run_fill($urandom_range(0, 330), $urandom_range(0, FB_H + 5),
                  $urandom_range(0, 12), $urandom_range(0, 5),
                  8'($urandom), $urandom_range(0, 25));
      chk("re_never_with_we", re_clash, 0);

      // swap requested during a clear: held off until the edge after cls_ack
      swap_ack_n = 0;
      cls_rq = 1; tick(); cls_rq = 0;
      repeat (5) tick();
      swap_rq = 1; tick(); swap_rq = 0;
      tick();
      swap_rq = 1; tick(); swap_rq = 0;
      vsync = 0; repeat (10) tick(); vsync = 1; repeat (10) tick();
      chk("swap_held_while_busy", bufswap, 0);
      i = 0; got = 0;
      while (i < FB_W * FB_H + 100 && !got) begin
         @(negedge clk);
         if (cls_ack) got = 1;
         tick();
         i++;
      end
      chk("swap_cls_done", int'(got), 1);
      repeat (5) tick();
      chk("swap_no_edge_yet", bufswap, 0);
      vsync = 0; repeat (10) tick(); vsync = 1; repeat (10) tick();
      chk("swap_toggled", bufswap, 1);
      chk("swap_ack_once", swap_ack_n, 1);
      vsync = 0; repeat (10) tick(); vsync = 1; repeat (10) tick();
      chk("swap_merged_one_toggle", bufswap, 1);
      chk("swap_ack_still_once", swap_ack_n, 1);

      // async reset mid-fill
      fill_x0 = 0; fill_y0 = 0; fill_w = 200; fill_h = 20; fill_val = 8'hEE;
      fill_rq = 1; tick(); fill_rq = 0;
      repeat (30) tick();
      i = fill_ack_n;
      @(negedge clk); #2;
      chk("pre_rst_busy", busy, 1);
      rst = 1;
      #1;
      chk("async_rst_we", vmem_we, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_bufswap", bufswap, 0);
      repeat (3) tick();
      rst = 0;
      repeat (3) tick();
      chk("rst_no_fill_ack", fill_ack_n - i, 0);
      run_fill(1, 1, 4, 2, 8'h9C, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vram_fill_ctrl.md
Name: vram_fill_ctrl

Overview:
- Sequencer and arbiter for the framebuffer write port of the double-buffered greyscale VRAM (FB_W x FB_H bytes, 153600 by default).
- Shares the single write port between CPU stores, a full-screen clear engine and a rectangle-fill engine.
- Schedules vsync-aligned buffer swaps.
- Sits between the CPU bus bridge and the VRAM pair; drives the buffer-select line consumed by the VGA scanout.

Parameters:
- FB_W, 320, bytes per line.
- FB_H, 480, lines.
- AW, 20, VRAM address width.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  reset.
- cpu_addr  in  AW  CPU byte address.
- cpu_data  in  8  CPU write data.
- cpu_we  in  1  CPU write strobe.
- cpu_re  in  1  CPU read strobe.
- cls_rq  in  1  clear request (level).
- cls_ack  out  1  clear-done pulse.
- fill_x0  in  9  rectangle left column (bytes).
- fill_y0  in  9  rectangle top line.
- fill_w  in  9  width (bytes).
- fill_h  in  9  height (lines).
- fill_val  in  8  fill byte.
- fill_rq  in  1  fill request (level).
- fill_ack  out  1  fill-done pulse.
- busy  out  1  engine not IDLE.
- swap_rq  in  1  buffer-swap request pulse.
- vsync  in  1  VGA vsync, active low.
- bufswap  out  1  front-buffer select.
- swap_ack  out  1  swap-done pulse.
- vmem_addr  out  AW  VRAM write-port address.
- vmem_data  out  8  VRAM write data.
- vmem_we  out  1  VRAM write enable.
- vmem_re  out  1  VRAM read enable.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - State machine in IDLE.
  - All outputs 0; bufswap=0.
  - Swap-pending flag cleared; counters cleared.
  - Reset mid-clear or mid-fill abandons the operation with no ack.
- Output timing: all vmem_* outputs are registered, so there is 1 cycle of latency from grant to port.
- Arbitration, every cycle:
  - cpu_we=1 wins: vmem_addr=cpu_addr, vmem_data=cpu_data, vmem_we=1. The engine holds its counters that cycle.
  - Else if the engine is active: engine write.
  - Else if cpu_re=1: vmem_addr=cpu_addr, vmem_re=1, vmem_we=0.
  - vmem_re is forced to 0 on any cycle the engine or the CPU writes.
- State machine IDLE -> SETUP -> CLS | FILL -> IDLE:
  - IDLE: cls_rq has priority over fill_rq when both are high. Requests are sampled only in IDLE and ignored while busy. A held level is re-accepted only after the ack.
  - SETUP (1 cycle, fill only):
    - Clip: wc = min(fill_w, FB_W - fill_x0); hc = min(fill_h, FB_H - fill_y0).
    - If fill_x0 >= FB_W, fill_y0 >= FB_H, wc=0 or hc=0: pulse fill_ack next cycle, no writes, back to IDLE.
    - row_base = fill_y0*FB_W + fill_x0 (constant multiply).
  - CLS: writes value 0 to addresses 0 .. FB_W*FB_H-1, one per granted cycle. After the last write, pulse cls_ack for 1 cycle and return to IDLE.
  - FILL:
    - Writes fill_val, captured in IDLE, at row_base + col for col 0..wc-1.
    - At end of row: row_base += FB_W (no multiplier), col=0.
    - After row hc-1, col wc-1: pulse fill_ack for 1 cycle, then IDLE.
- Width rules:
  - Address arithmetic in AW bits; no wrap is possible after clipping.
  - Rectangle parameters are captured in IDLE; later input changes are ignored.
- Buffer swap:
  - A swap_rq pulse sets swap_pending; extra requests while pending are merged.
  - Swap executes on the cycle following a falling edge of vsync (vsync synchronised through 2 flops, edge detected on the synchronised value), only when state is IDLE.
  - If the engine is busy at the edge, the swap waits for the next falling edge.
  - Execution: bufswap toggles, swap_ack pulses 1 cycle, swap_pending clears.
  - A swap_rq arriving in the same cycle as execution re-arms swap_pending.

Optional Feature:
- Macro: FILL_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in CLS or FILL returns the engine to IDLE the next cycle with no further writes, and pulses the matching ack.
  - abort in IDLE or SETUP is ignored; SETUP completes normally.
- Undefined: no abort port; an operation always runs to completion.

Test Plan:
- Reset, then cls_rq=1: exactly 153600 writes of 0 at addresses 0..153599, busy=1 throughout, single cls_ack pulse, busy=0 the cycle after.
- Fill x0=10, y0=2, w=3, h=2, val=0x5A: writes at 650, 651, 652, 970, 971, 972 only, then fill_ack.
- Fill x0=318, y0=479, w=5, h=5: clipped to writes at 153598 and 153599 only; x0=320: ack with zero writes.
- cpu_we asserted for 4 cycles during a fill: CPU addresses appear on the port in those cycles, engine sequence resumes without skip or duplicate, total engine writes unchanged.
- swap_rq during a clear, with vsync falling edges mid-clear and after: bufswap stays 0 until the first falling edge after cls_ack, then 1 with one swap_ack; two swap_rq pulses before the edge give only one toggle.
- Async rst asserted mid-fill without a clock edge: outputs go to 0 immediately, no fill_ack, bufswap=0; a new fill after release runs normally.
